// File: rtl/led_seq_pkg.sv
// LED bring-up sequencer shared types.
// States, pattern modes and pattern reload helper.
package led_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_BIN  = 2'd0,
    MODE_WALK = 2'd1,
    MODE_PING = 2'd2,
    MODE_ALL  = 2'd3
  } mode_t;

  localparam int MAX_LEDS = 64;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Result is MAX_LEDS wide; callers keep the low n bits.
  function automatic logic [MAX_LEDS-1:0] init_pattern(
    input mode_t m,
    input int    n
  );
    logic [MAX_LEDS-1:0] v;
    v = '0;
    unique case (m)
      MODE_BIN:  v = '0;
      MODE_WALK: v = MAX_LEDS'(1);
      MODE_PING: v = MAX_LEDS'(1);
      MODE_ALL:  v = {MAX_LEDS{1'b1}} >> (MAX_LEDS - n);
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/led_bringup_seq_tick_prescaler.sv
// Free-running step prescaler for the LED sequencer.
// Emits a one-cycle tick every DIV cycles; clr restarts the count.
module tick_prescaler
  import led_seq_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic clkin,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = cnt_w(DIV);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(DIV - 1));
  assign tick   = w_last;

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/led_bringup_seq.sv
// Fabric LED bank bring-up sequencer.
// Waits for stable lock/init, shows a pattern, blinks on lock loss.
module led_bringup_seq
  import led_seq_pkg::*;
#(
  parameter int N_LEDS        = 12,
  parameter int TICK_DIV      = 50_000_000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOST_BLINKS   = 4
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              pll_lock,
  input  logic              init_done,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] leds,
  output logic [1:0]        state,
  output logic              running
);

  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam int BW = cnt_w(LOST_BLINKS);

  state_t            r_state, w_state_n;
  logic [N_LEDS-1:0] r_leds, w_leds_n;
  logic [SW-1:0]     r_settle, w_settle_n;
  logic [BW-1:0]     r_blink, w_blink_n;
  mode_t             r_act, w_act_n;
  logic              r_dir, w_dir_n;
  logic              r_running;

  logic                w_qual;
  logic                w_tick;
  logic                w_clr;
  mode_t               w_mode;
  logic [MAX_LEDS-1:0] w_init_full;
  logic [N_LEDS-1:0]   w_init;
  logic [N_LEDS-1:0]   w_up;
  logic [N_LEDS-1:0]   w_dn;

  assign w_qual      = pll_lock & init_done;
  assign w_mode      = mode_t'(mode);
  assign w_init_full = init_pattern(w_mode, N_LEDS);
  assign w_init      = w_init_full[N_LEDS-1:0];
  assign w_up        = r_leds << 1;
  assign w_dn        = r_leds >> 1;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_presc (
    .clkin (clkin),
    .rst   (rst),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state   <= WAIT_LOCK;
      r_leds    <= '0;
      r_settle  <= '0;
      r_blink   <= '0;
      r_act     <= MODE_BIN;
      r_dir     <= 1'b1;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_leds    <= w_leds_n;
      r_settle  <= w_settle_n;
      r_blink   <= w_blink_n;
      r_act     <= w_act_n;
      r_dir     <= w_dir_n;
      r_running <= (w_state_n == RUN);
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_leds_n   = r_leds;
    w_settle_n = r_settle;
    w_blink_n  = r_blink;
    w_act_n    = r_act;
    w_dir_n    = r_dir;
    w_clr      = 1'b0;
    unique case (r_state)
      WAIT_LOCK: begin
        w_leds_n = '0;
        if (w_qual) begin
          w_state_n  = SETTLE;
          w_settle_n = '0;
        end
      end
      SETTLE: begin
        w_leds_n = '0;
        if (!w_qual) begin
          w_state_n  = WAIT_LOCK;
          w_settle_n = '0;
        end else if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
          w_state_n  = RUN;
          w_settle_n = '0;
          w_act_n    = w_mode;
          w_leds_n   = w_init;
          w_dir_n    = 1'b1;
          w_clr      = 1'b1;
        end else begin
          w_settle_n = r_settle + SW'(1);
        end
      end
      RUN: begin
        // Lock loss wins over a same-cycle pattern step.
        if (!w_qual) begin
          w_state_n = FAULT;
          w_leds_n  = '1;
          w_blink_n = '0;
          w_clr     = 1'b1;
        end else if (w_tick) begin
          if (w_mode != r_act) begin
            w_act_n  = w_mode;
            w_leds_n = w_init;
            w_dir_n  = 1'b1;
          end else begin
            unique case (r_act)
              MODE_BIN:  w_leds_n = r_leds + N_LEDS'(1);
              MODE_WALK: w_leds_n = {r_leds[N_LEDS-2:0], r_leds[N_LEDS-1]};
              MODE_PING: begin
                if (r_dir) begin
                  w_leds_n = w_up;
                  if (w_up[N_LEDS-1]) w_dir_n = 1'b0;
                end else begin
                  w_leds_n = w_dn;
                  if (w_dn[0]) w_dir_n = 1'b1;
                end
              end
              MODE_ALL:  w_leds_n = r_leds;
              default:   w_leds_n = r_leds;
            endcase
          end
        end
      end
      FAULT: begin
        if (w_tick) begin
          w_leds_n = ~r_leds;
          if (r_leds == '1) begin
            if (r_blink == BW'(LOST_BLINKS - 1)) begin
              w_state_n = WAIT_LOCK;
              w_leds_n  = '0;
              w_blink_n = '0;
            end else begin
              w_blink_n = r_blink + BW'(1);
            end
          end
        end
      end
      default: w_state_n = WAIT_LOCK;
    endcase
  end

  assign leds    = r_leds;
  assign state   = r_state;
  assign running = r_running;

endmodule

// File: tb/tb_led_bringup_seq.sv
// Directed bench for led_bringup_seq.
// N=12, TICK_DIV=4, SETTLE=8, LOST_BLINKS=2.
module tb_led_bringup_seq;

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        pll_lock = 1'b0;
  logic        init_done = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] leds;
  logic [1:0]  state;
  logic        running;

  int total = 0;
  int bad   = 0;

  always #5 clkin = ~clkin;

  led_bringup_seq #(
    .N_LEDS        (12),
    .TICK_DIV      (4),
    .SETTLE_CYCLES (8),
    .LOST_BLINKS   (2)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .init_done (init_done),
    .mode      (mode),
    .leds      (leds),
    .state     (state),
    .running   (running)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic go_run(input logic [1:0] m);
    rst = 1'b1;
    pll_lock = 1'b1;
    init_done = 1'b1;
    mode = m;
    step(1);
    rst = 1'b0;
    step(9);
    total++;
    if (state !== 2'd2) begin
      bad++;
      $display("FAIL go_run state got=%0d want=2", state);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pll_lock = 1'b1;
    init_done = 1'b1;
    step(2);
    total++;
    if ({state, leds, running} !== 15'd0) begin
      bad++;
      $display("FAIL reset state=%0d leds=%h run=%b want 0/000/0",
               state, leds, running);
    end
  endtask

  task automatic test_settle_run;
    mode = 2'd0;
    rst = 1'b0;
    step(8);
    total++;
    if (state !== 2'd1 || running !== 1'b0) begin
      bad++;
      $display("FAIL settle_e7 state=%0d run=%b want 1/0", state, running);
    end
    step(1);
    total++;
    if (state !== 2'd2 || running !== 1'b1 || leds !== 12'h000) begin
      bad++;
      $display("FAIL run_entry state=%0d run=%b leds=%h want 2/1/000",
               state, running, leds);
    end
    step(3);
    total++;
    if (leds !== 12'h000) begin
      bad++;
      $display("FAIL pre_tick leds=%h want 000", leds);
    end
    step(1);
    total++;
    if (leds !== 12'h001) begin
      bad++;
      $display("FAIL first_tick leds=%h want 001", leds);
    end
  endtask

  task automatic test_settle_abort;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(6);
    pll_lock = 1'b0;
    step(1);
    total++;
    if (state !== 2'd0 || leds !== 12'h000) begin
      bad++;
      $display("FAIL abort state=%0d leds=%h want 0/000", state, leds);
    end
    pll_lock = 1'b1;
    step(8);
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL rearm_e7 state=%0d want 1", state);
    end
    step(1);
    total++;
    if (state !== 2'd2) begin
      bad++;
      $display("FAIL rearm_run state=%0d want 2", state);
    end
  endtask

  task automatic test_ping;
    int pos;
    int dir;
    logic [11:0] exp;
    go_run(2'd2);
    total++;
    if (leds !== 12'h001) begin
      bad++;
      $display("FAIL ping_init leds=%h want 001", leds);
    end
    pos = 0;
    dir = 1;
    for (int k = 0; k < 24; k++) begin
      pos = pos + dir;
      if (pos == 11) dir = -1;
      if (pos == 0) dir = 1;
      exp = 12'h001 << pos;
      step(4);
      total++;
      if (leds !== exp) begin
        bad++;
        $display("FAIL ping_step%0d leds=%h want %h", k, leds, exp);
      end
    end
  endtask

  task automatic test_walk;
    logic [11:0] exp;
    go_run(2'd1);
    for (int i = 1; i <= 13; i++) begin
      exp = 12'h001 << (i % 12);
      step(4);
      total++;
      if (leds !== exp) begin
        bad++;
        $display("FAIL walk_step%0d leds=%h want %h", i, leds, exp);
      end
    end
  endtask

  task automatic test_bin_wrap;
    go_run(2'd0);
    step(4 * 4095);
    total++;
    if (leds !== 12'hFFF) begin
      bad++;
      $display("FAIL bin_full leds=%h want fff", leds);
    end
    step(4);
    total++;
    if (leds !== 12'h000) begin
      bad++;
      $display("FAIL bin_wrap leds=%h want 000", leds);
    end
  endtask

  task automatic test_mode_switch;
    go_run(2'd1);
    step(4);
    step(2);
    mode = 2'd3;
    step(1);
    total++;
    if (leds !== 12'h002) begin
      bad++;
      $display("FAIL sw_hold leds=%h want 002", leds);
    end
    step(1);
    total++;
    if (leds !== 12'hFFF) begin
      bad++;
      $display("FAIL sw_tick leds=%h want fff", leds);
    end
    step(4);
    total++;
    if (leds !== 12'hFFF) begin
      bad++;
      $display("FAIL sw_allon leds=%h want fff", leds);
    end
  endtask

  task automatic test_fault;
    go_run(2'd1);
    step(3);
    pll_lock = 1'b0;
    step(1);
    total++;
    if (state !== 2'd3 || leds !== 12'hFFF || running !== 1'b0) begin
      bad++;
      $display("FAIL fault_entry state=%0d leds=%h run=%b want 3/fff/0",
               state, leds, running);
    end
    step(1);
    pll_lock = 1'b1;
    step(3);
    total++;
    if (state !== 2'd3 || leds !== 12'h000) begin
      bad++;
      $display("FAIL fault_f4 state=%0d leds=%h want 3/000", state, leds);
    end
    step(4);
    total++;
    if (leds !== 12'hFFF) begin
      bad++;
      $display("FAIL fault_f8 leds=%h want fff", leds);
    end
    step(3);
    total++;
    if (state !== 2'd3 || leds !== 12'hFFF) begin
      bad++;
      $display("FAIL fault_f11 state=%0d leds=%h want 3/fff", state, leds);
    end
    step(1);
    total++;
    if (state !== 2'd0 || leds !== 12'h000) begin
      bad++;
      $display("FAIL fault_f12 state=%0d leds=%h want 0/000", state, leds);
    end
  endtask

  task automatic test_rst_mid;
    go_run(2'd0);
    pll_lock = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    total++;
    if ({state, leds, running} !== 15'd0) begin
      bad++;
      $display("FAIL rst_fault state=%0d leds=%h run=%b want 0/000/0",
               state, leds, running);
    end
    pll_lock = 1'b1;
    rst = 1'b0;
    step(3);
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL pre_rst_settle state=%0d want 1", state);
    end
    rst = 1'b1;
    step(1);
    total++;
    if ({state, leds, running} !== 15'd0) begin
      bad++;
      $display("FAIL rst_settle state=%0d leds=%h run=%b want 0/000/0",
               state, leds, running);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_settle_run();
    test_settle_abort();
    test_ping();
    test_walk();
    test_bin_wrap();
    test_mode_switch();
    test_fault();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
